// File: rtl/dff_lane_arbiter.sv
// Round-robin arbiter that serializes WIDTH-bit words LSB-first onto a single-bit DFF lane.
// Adds lane framing: lane_en, sof and grant_id, plus a forced idle gap after each word.
module dff_lane_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       din,
  output logic                       lane_en,
  output logic                       sof,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [BW-1:0]    bitcnt_reg, bitcnt_next;
  logic [GW-1:0]    gapcnt_reg, gapcnt_next;
  logic [IW-1:0]    last_grant_reg, last_grant_next;
  logic             din_reg, din_next;
  logic             lane_en_reg, lane_en_next;
  logic             sof_reg, sof_next;
  logic [IW-1:0]    grant_id_reg, grant_id_next;
  logic             busy_reg, busy_next;

  logic [WIDTH-1:0] words [NUM_REQ];
  logic             found;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    cand;
  logic             accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign words[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Index last_grant+off modulo NUM_REQ; NUM_REQ need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IW-1:0];
  endfunction

  // Search starts just after the previous winner, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = wrap_add(last_grant_reg, off);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_reg == IDLE && found && !rst) req_ready[pick] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_next      = state_reg;
    shreg_next      = shreg_reg;
    bitcnt_next     = bitcnt_reg;
    gapcnt_next     = gapcnt_reg;
    last_grant_next = last_grant_reg;
    din_next        = din_reg;
    lane_en_next    = lane_en_reg;
    sof_next        = sof_reg;
    grant_id_next   = grant_id_reg;
    busy_next       = busy_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          shreg_next      = words[pick] >> 1;
          din_next        = words[pick][0];
          last_grant_next = pick;
          grant_id_next   = pick;
          lane_en_next    = 1'b1;
          sof_next        = 1'b1;
          busy_next       = 1'b1;
          bitcnt_next     = '0;
          state_next      = SHIFT;
        end
      end
      SHIFT: begin
        sof_next = 1'b0;
        if (bitcnt_reg == BIT_LAST) begin
          din_next     = 1'b0;
          lane_en_next = 1'b0;
          gapcnt_next  = '0;
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
          end
        end else begin
          bitcnt_next = bitcnt_reg + 1'b1;
          din_next    = shreg_reg[0];
          shreg_next  = shreg_reg >> 1;
        end
      end
      GAP: begin
        if (gapcnt_reg == GAP_LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          gapcnt_next = gapcnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        din_next     = 1'b0;
        lane_en_next = 1'b0;
        sof_next     = 1'b0;
        busy_next    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shreg_reg      <= '0;
      bitcnt_reg     <= '0;
      gapcnt_reg     <= '0;
      last_grant_reg <= LAST_INIT;
      din_reg        <= 1'b0;
      lane_en_reg    <= 1'b0;
      sof_reg        <= 1'b0;
      grant_id_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shreg_reg      <= shreg_next;
      bitcnt_reg     <= bitcnt_next;
      gapcnt_reg     <= gapcnt_next;
      last_grant_reg <= last_grant_next;
      din_reg        <= din_next;
      lane_en_reg    <= lane_en_next;
      sof_reg        <= sof_next;
      grant_id_reg   <= grant_id_next;
      busy_reg       <= busy_next;
    end
  end

  assign din      = din_reg;
  assign lane_en  = lane_en_reg;
  assign sof      = sof_reg;
  assign grant_id = grant_id_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_dff_lane_arbiter.sv
// Directed bench for dff_lane_arbiter: default build plus a 2-requester, zero-gap build.
// A downstream DFF model (dout) checks the one-cycle lane delay.
module tb_dff_lane_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        din, lane_en, sof, busy;
  logic [1:0]  grant_id;
  logic [1:0]  v2 = '0;
  logic [15:0] d2 = '0;
  logic [1:0]  r2;
  logic        din2, len2, sof2, busy2;
  logic [0:0]  g2;
  logic        dout;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) dout <= din;

  dff_lane_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .din(din), .lane_en(lane_en), .sof(sof),
    .grant_id(grant_id), .busy(busy)
  );

  dff_lane_arbiter #(.NUM_REQ(2), .WIDTH(8), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_data(d2),
    .req_ready(r2), .din(din2), .lane_en(len2), .sof(sof2),
    .grant_id(g2), .busy(busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || busy2) && n < 30) begin tick(); n++; end
    checks++;
    if (busy || busy2) begin errors++; $display("FAIL %s_idle_timeout busy=%b busy2=%b want 0", name, busy, busy2); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = 32'h44332211; v2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({req_ready, lane_en, din, busy} !== 7'b0) begin
        errors++; $display("FAIL reset_outputs cycle %0d ready=%b lane_en=%b din=%b busy=%b want all 0", i, req_ready, lane_en, din, busy);
      end
      checks++;
      if ({r2, len2, din2, busy2} !== 5'b0) begin
        errors++; $display("FAIL reset_outputs_gap0 cycle %0d ready=%b lane_en=%b din=%b busy=%b want all 0", i, r2, len2, din2, busy2);
      end
    end
    checks++;
    if ({sof, grant_id} !== 3'b0) begin errors++; $display("FAIL reset_sof_gid sof=%b gid=%0d want 0 0", sof, grant_id); end
    rst = 1'b0; req_valid = '0; v2 = '0;
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hA5;
    req_data[23:16] = w; req_valid = 4'b0100; #1;
    checks++;
    if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want 0100", req_ready); end
    tick(); req_valid = '0; #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop got %b want 0000", req_ready); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({din, lane_en, sof, grant_id} !== {w[k], 1'b1, (k == 0), 2'd2}) begin
        errors++; $display("FAIL single_bit%0d din/en/sof/gid=%b%b%b/%0d want %b11%b/2", k, din, lane_en, sof, grant_id, w[k], (k == 0));
      end
      if (k > 0) begin
        checks++;
        if (dout !== w[k-1]) begin errors++; $display("FAIL single_dout%0d got %b want %b", k-1, dout, w[k-1]); end
      end
      tick();
    end
    checks++;
    if ({lane_en, din, dout, busy} !== {1'b0, 1'b0, w[7], 1'b1}) begin
      errors++; $display("FAIL single_end en/din/dout/busy=%b%b%b%b want 00%b1", lane_en, din, dout, busy, w[7]);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_clear got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    int idle, n;
    logic [7:0] got;
    rst = 1'b1; tick(); rst = 1'b0;
    req_data = 32'h44332211; req_valid = 4'hF;
    for (int w = 0; w < 5; w++) begin
      idle = 0; n = 0;
      while (!(lane_en && sof) && n < 40) begin if (!lane_en) idle++; tick(); n++; end
      checks++;
      if (!(lane_en && sof)) begin errors++; $display("FAIL rr_timeout word %0d no sof", w); end
      checks++;
      if (grant_id !== 2'(exp_g[w])) begin errors++; $display("FAIL rr_order word %0d gid=%0d want %0d", w, grant_id, exp_g[w]); end
      if (w > 0) begin
        checks++;
        if (idle != 2) begin errors++; $display("FAIL rr_gap word %0d idle=%0d want 2", w, idle); end
      end
      for (int b = 0; b < 8; b++) begin got[b] = din; tick(); end
      checks++;
      if (got !== req_data[exp_g[w]*8 +: 8]) begin errors++; $display("FAIL rr_data word %0d got %h want %h", w, got, req_data[exp_g[w]*8 +: 8]); end
    end
    req_valid = '0;
    wait_idle("rr");
  endtask

  task automatic test_priority_wrap();
    int n = 0;
    req_data[31:24] = 8'h3C; req_data[15:8] = 8'h69;
    req_valid = 4'b1000; #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_prime_ready got %b want 1000", req_ready); end
    tick(); req_valid = '0;
    wait_idle("wrap_prime");
    req_valid = 4'b1010; #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL wrap_ready got %b want 0010", req_ready); end
    tick();
    checks++;
    if ({sof, grant_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL wrap_first sof=%b gid=%0d want 1 1", sof, grant_id); end
    req_valid = 4'b1000; #1;
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("FAIL wrap_ready_busy got %b want 0000", req_ready); end
    tick();
    while (!sof && n < 40) begin tick(); n++; end
    checks++;
    if ({sof, grant_id} !== {1'b1, 2'd3}) begin errors++; $display("FAIL wrap_second sof=%b gid=%0d want 1 3", sof, grant_id); end
    req_valid = '0;
    wait_idle("wrap");
  endtask

  task automatic test_reset_mid_word();
    req_data[31:24] = 8'hFF; req_valid = 4'b1000; #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL abort_ready got %b want 1000", req_ready); end
    tick(); req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if ({din, lane_en, sof} !== 3'b110) begin errors++; $display("FAIL abort_bit4 din/en/sof=%b%b%b want 110", din, lane_en, sof); end
    rst = 1'b1; tick();
    checks++;
    if ({din, lane_en, sof, busy, grant_id} !== 6'b0) begin
      errors++; $display("FAIL abort_reset din/en/sof/busy/gid=%b%b%b%b/%0d want 0000/0", din, lane_en, sof, busy, grant_id);
    end
    rst = 1'b0; tick();
    checks++;
    if ({lane_en, busy} !== 2'b00) begin errors++; $display("FAIL abort_no_reserve en/busy=%b%b want 00", lane_en, busy); end
    req_data[31:24] = 8'hFE; req_valid = 4'b1000; #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL abort_next_ready got %b want 1000", req_ready); end
    tick(); req_valid = '0;
    checks++;
    if ({din, lane_en, sof, grant_id} !== {1'b0, 1'b1, 1'b1, 2'd3}) begin
      errors++; $display("FAIL abort_fresh_bit0 din/en/sof/gid=%b%b%b/%0d want 011/3", din, lane_en, sof, grant_id);
    end
    tick();
    checks++;
    if ({din, sof} !== 2'b10) begin errors++; $display("FAIL abort_fresh_bit1 din/sof=%b%b want 10", din, sof); end
    wait_idle("abort");
  endtask

  task automatic test_gap0_back_to_back();
    int exp_g [3] = '{0, 1, 0};
    int idle, n;
    logic [7:0] got;
    d2 = 16'h96C3; v2 = 2'b11;
    for (int w = 0; w < 3; w++) begin
      idle = 0; n = 0;
      while (!(len2 && sof2) && n < 40) begin if (!len2) idle++; tick(); n++; end
      checks++;
      if (!(len2 && sof2)) begin errors++; $display("FAIL gap0_timeout word %0d no sof", w); end
      checks++;
      if (g2 !== 1'(exp_g[w])) begin errors++; $display("FAIL gap0_order word %0d gid=%0d want %0d", w, g2, exp_g[w]); end
      if (w > 0) begin
        checks++;
        if (idle != 1) begin errors++; $display("FAIL gap0_gap word %0d idle=%0d want 1", w, idle); end
      end
      for (int b = 0; b < 8; b++) begin got[b] = din2; tick(); end
      checks++;
      if (got !== d2[exp_g[w]*8 +: 8]) begin errors++; $display("FAIL gap0_data word %0d got %h want %h", w, got, d2[exp_g[w]*8 +: 8]); end
    end
    v2 = '0;
    wait_idle("gap0");
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_round_robin();
    test_priority_wrap();
    test_reset_mid_word();
    test_gap0_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
